// File: rtl/controlador_rolhas.sv
// controlador_rolhas
// Sequencing controller for the cork-capping station. Owns the hopper's
// 7-bit parallel-load down counter: loads it with CAPACIDADE, clocks one
// decrement per confirmed cork, and watches Q to request refills and to
// light the low-stock lamp.
//
// Ports:
//   i_clk             system clock, rising edge
//   i_rst             asynchronous reset, active-high
//   i_q               current count read back from the down counter
//   i_garrafa         bottle-in-position sensor (async, level)
//   i_sensor_rolha    cork-passed sensor (async, pulse >= 1 clock)
//   i_reposicao_ok    operator acknowledge, hopper refilled (async, level)
//   o_p               counter parallel-load value, constant CAPACIDADE
//   o_pload           counter load strobe, active-low
//   o_conta           counter clock, counter decrements on its rising edge
//   o_valvula         dispense valve open
//   o_pede_reposicao  refill request
//   o_baixo_estoque   low-stock lamp, 0 < Q <= LIMIAR_BAIXO
//   o_falha           dispense fault
//
// Build option: define ALARME_TIMEOUT_EN to enable the dispense timeout.
// Without it the valve waits for the cork indefinitely and o_falha is 0.
//
// state          | meaning
// ---------------+------------------------------------------------------
// CARGA          | reload counter: one idle cycle, then PLoad low 2 cycles
// ESPERA_Q       | 2 settle cycles, then Q==0 -> refill, else wait bottle
// ESPERA_GARRAFA | wait for a bottle in position
// DISPENSA       | valve open until the cork is sensed
// CONTAGEM       | one-cycle CONTA pulse, decrements the counter
// ESPERA_SAIDA   | wait for the bottle to leave
// REPOSICAO      | refill request until the operator acknowledges
// FALHA_ST       | dispense timeout, left only by reset (optional build)

module controlador_rolhas #(
  parameter int CAPACIDADE   = 100,
  parameter int LIMIAR_BAIXO = 10,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_q,
  input  logic       i_garrafa,
  input  logic       i_sensor_rolha,
  input  logic       i_reposicao_ok,
  output logic [6:0] o_p,
  output logic       o_pload,
  output logic       o_conta,
  output logic       o_valvula,
  output logic       o_pede_reposicao,
  output logic       o_baixo_estoque,
  output logic       o_falha
);

  localparam logic [6:0] CAP = 7'(CAPACIDADE);
  localparam logic [6:0] LIM = 7'(LIMIAR_BAIXO);

  typedef enum logic [2:0] {
    CARGA,
    ESPERA_Q,
    ESPERA_GARRAFA,
    DISPENSA,
    CONTAGEM,
    ESPERA_SAIDA,
    REPOSICAO,
    FALHA_ST
  } state_t;

  state_t     r_state, w_next;
  logic [1:0] r_tmr, w_tmr_nx;
  logic       r_pload, r_conta, r_valvula, r_pede, r_baixo;
  logic       w_pload_nx, w_conta_nx, w_valvula_nx, w_pede_nx;

  // bit 0 garrafa, bit 1 sensor_rolha, bit 2 reposicao_ok
  logic [2:0] r_sync [SYNC_STAGES];
  logic [2:0] w_sync;
  logic       w_garrafa_s, w_sensor_s, w_ok_s;
  logic       r_sensor_d, w_sensor_ev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= 3'b000;
      r_sensor_d <= 1'b0;
    end else begin
      r_sync[0] <= {i_reposicao_ok, i_sensor_rolha, i_garrafa};
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_sensor_d <= w_sensor_s;
    end
  end

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_garrafa_s = w_sync[0];
  assign w_sensor_s  = w_sync[1];
  assign w_ok_s      = w_sync[2];
  assign w_sensor_ev = w_sensor_s & ~r_sensor_d;

`ifdef ALARME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo, w_tmo_nx;
  logic          r_falha, w_falha_nx;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= CARGA;
      r_tmr     <= 2'd2;
      r_pload   <= 1'b1;
      r_conta   <= 1'b0;
      r_valvula <= 1'b0;
      r_pede    <= 1'b0;
      r_baixo   <= 1'b0;
`ifdef ALARME_TIMEOUT_EN
      r_tmo     <= '0;
      r_falha   <= 1'b0;
`endif
    end else begin
      r_state   <= w_next;
      r_tmr     <= w_tmr_nx;
      r_pload   <= w_pload_nx;
      r_conta   <= w_conta_nx;
      r_valvula <= w_valvula_nx;
      r_pede    <= w_pede_nx;
      // Q is meaningless while it is being reloaded
      r_baixo   <= (r_state != CARGA) && (i_q != 7'd0) && (i_q <= LIM);
`ifdef ALARME_TIMEOUT_EN
      r_tmo     <= w_tmo_nx;
      r_falha   <= w_falha_nx;
`endif
    end
  end

  // Outputs are registered from the next-state decision, so each output
  // flop reflects the state that is being entered.
  always_comb begin
    w_next       = r_state;
    w_tmr_nx     = r_tmr;
    w_pload_nx   = 1'b1;
    w_conta_nx   = 1'b0;
    w_valvula_nx = 1'b0;
    w_pede_nx    = 1'b0;
`ifdef ALARME_TIMEOUT_EN
    w_tmo_nx     = r_tmo;
    w_falha_nx   = 1'b0;
`endif
    case (r_state)
      CARGA: begin
        if (r_tmr != 2'd0) begin
          w_pload_nx = 1'b0;
          w_tmr_nx   = r_tmr - 2'd1;
        end else begin
          w_next   = ESPERA_Q;
          w_tmr_nx = 2'd2;
        end
      end
      ESPERA_Q: begin
        if (r_tmr != 2'd0) begin
          w_tmr_nx = r_tmr - 2'd1;
        end else if (i_q == 7'd0) begin
          w_next    = REPOSICAO;
          w_pede_nx = 1'b1;
        end else begin
          w_next = ESPERA_GARRAFA;
        end
      end
      ESPERA_GARRAFA: begin
        if (w_garrafa_s) begin
          w_next       = DISPENSA;
          w_valvula_nx = 1'b1;
`ifdef ALARME_TIMEOUT_EN
          w_tmo_nx     = TW'(TIMEOUT);
`endif
        end
      end
      DISPENSA: begin
        // bottle leaving is ignored here: the cork in flight must be counted
        if (w_sensor_ev) begin
          w_next     = CONTAGEM;
          w_conta_nx = 1'b1;
`ifdef ALARME_TIMEOUT_EN
        end else if (r_tmo <= TW'(1)) begin
          w_next     = FALHA_ST;
          w_falha_nx = 1'b1;
`endif
        end else begin
          w_valvula_nx = 1'b1;
`ifdef ALARME_TIMEOUT_EN
          w_tmo_nx     = r_tmo - TW'(1);
`endif
        end
      end
      CONTAGEM: begin
        w_next = ESPERA_SAIDA;
      end
      ESPERA_SAIDA: begin
        if (!w_garrafa_s) begin
          w_next   = ESPERA_Q;
          w_tmr_nx = 2'd2;
        end
      end
      REPOSICAO: begin
        if (w_ok_s) begin
          w_next   = CARGA;
          w_tmr_nx = 2'd2;
        end else begin
          w_pede_nx = 1'b1;
        end
      end
`ifdef ALARME_TIMEOUT_EN
      FALHA_ST: begin
        w_falha_nx = 1'b1;
      end
`endif
      default: begin
        w_next   = CARGA;
        w_tmr_nx = 2'd2;
      end
    endcase
  end

  assign o_p              = CAP;
  assign o_pload          = r_pload;
  assign o_conta          = r_conta;
  assign o_valvula        = r_valvula;
  assign o_pede_reposicao = r_pede;
  assign o_baixo_estoque  = r_baixo;
`ifdef ALARME_TIMEOUT_EN
  assign o_falha          = r_falha;
`else
  assign o_falha          = 1'b0;
`endif

endmodule

// File: tb/tb_controlador_rolhas.sv
module tb_controlador_rolhas;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       garrafa = 1'b0;
  logic       sensor = 1'b0;
  logic       repos_ok = 1'b0;
  logic [6:0] q_cnt = 7'd0;
  logic [6:0] q_prev = 7'd0;
  logic [6:0] o_p;
  logic       o_pload, o_conta, o_valvula, o_pede_reposicao, o_baixo_estoque, o_falha;

  int total = 0;
  int bad = 0;
  int conta_events = 0;
  logic conta_prev = 1'b0;

  controlador_rolhas dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_q              (q_cnt),
    .i_garrafa        (garrafa),
    .i_sensor_rolha   (sensor),
    .i_reposicao_ok   (repos_ok),
    .o_p              (o_p),
    .o_pload          (o_pload),
    .o_conta          (o_conta),
    .o_valvula        (o_valvula),
    .o_pede_reposicao (o_pede_reposicao),
    .o_baixo_estoque  (o_baixo_estoque),
    .o_falha          (o_falha)
  );

  always #5 clk = ~clk;

  // Hopper counter: asynchronous parallel load while PLoad is low,
  // decrement on CONTA rising edge, never below zero.
  always @(posedge o_conta or negedge o_pload) begin
    if (!o_pload) q_cnt <= o_p;
    else if (q_cnt != 7'd0) q_cnt <= q_cnt - 7'd1;
  end

  always @(posedge clk) q_prev <= q_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Rules that hold on every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("p_const", int'(o_p), 100);
      chk("baixo_rule", int'(o_baixo_estoque),
          (q_prev != 7'd0 && q_prev <= 7'd10) ? 1 : 0);
      chk("conta_pload_excl", (o_conta && !o_pload) ? 1 : 0, 0);
      chk("conta_one_cycle", (o_conta && conta_prev) ? 1 : 0, 0);
      chk("pede_only_empty", (o_pede_reposicao && q_cnt != 7'd0) ? 1 : 0, 0);
`ifndef ALARME_TIMEOUT_EN
      chk("falha_tied", int'(o_falha), 0);
`endif
      if (o_conta && !conta_prev) conta_events++;
    end
    conta_prev = o_conta;
  end

  task automatic pulse_sensor();
    sensor = 1'b1;
    cyc(1);
    sensor = 1'b0;
  endtask

  // One full bottle: valve latency, cork pulse, one count, bottle leaves.
  task automatic dispensa(input int sdelay);
    int n;
    int c0;
    int q0;
    q0 = int'(q_cnt);
    c0 = conta_events;
    garrafa = 1'b1;
    n = 0;
    while (!o_valvula && n < 20) begin cyc(1); n++; end
    chk("lat_valvula", n, 3);
    cyc(sdelay);
    chk("valvula_held", int'(o_valvula), 1);
    sensor = 1'b1;
    cyc(1);
    sensor = 1'b0;
    n = 1;
    while (!o_conta && n < 20) begin cyc(1); n++; end
    chk("lat_conta", n, 3);
    chk("valvula_closed", int'(o_valvula), 0);
    cyc(3);
    chk("one_count", conta_events - c0, 1);
    chk("q_dec", int'(q_cnt), (q0 > 0) ? q0 - 1 : 0);
    garrafa = 1'b0;
    cyc(8);
  endtask

  task automatic count_pload_lows(input int win, output int lows);
    lows = 0;
    repeat (win) begin
      cyc(1);
      if (!o_pload) lows++;
    end
  endtask

  initial begin
    int n;
    int lows;
    int c0;

    cyc(3);
    chk("rst_pload", int'(o_pload), 1);
    chk("rst_conta", int'(o_conta), 0);
    chk("rst_valvula", int'(o_valvula), 0);
    chk("rst_pede", int'(o_pede_reposicao), 0);
    chk("rst_baixo", int'(o_baixo_estoque), 0);
    chk("rst_falha", int'(o_falha), 0);
    chk("rst_p", int'(o_p), 100);
    rst = 1'b0;
    count_pload_lows(10, lows);
    chk("init_pload_width", lows, 2);
    chk("init_q", int'(q_cnt), 100);
    chk("init_valvula", int'(o_valvula), 0);

    // 100 -> 10
    for (int i = 0; i < 90; i++) begin
      dispensa(5);
      if (q_cnt == 7'd11) chk("baixo_at_11", int'(o_baixo_estoque), 0);
    end
    chk("q_at_10", int'(q_cnt), 10);
    chk("baixo_at_10", int'(o_baixo_estoque), 1);
    for (int i = 0; i < 9; i++) dispensa(2 + i);
    chk("q_at_1", int'(q_cnt), 1);
    chk("baixo_at_1", int'(o_baixo_estoque), 1);
    dispensa(5);
    chk("q_at_0", int'(q_cnt), 0);
    chk("pede_at_0", int'(o_pede_reposicao), 1);
    chk("baixo_at_0", int'(o_baixo_estoque), 0);

    // empty hopper: bottle and cork pulses must not dispense or count
    c0 = conta_events;
    garrafa = 1'b1;
    n = 0;
    repeat (10) begin cyc(1); if (o_valvula) n++; end
    pulse_sensor();
    cyc(6);
    chk("empty_no_valve", n, 0);
    chk("empty_no_count", conta_events - c0, 0);
    chk("empty_q", int'(q_cnt), 0);
    garrafa = 1'b0;
    cyc(3);

    // refill handshake
    repos_ok = 1'b1;
    n = 0;
    while (o_pload && n < 20) begin cyc(1); n++; end
    chk("refill_pload_seen", (n < 20) ? 1 : 0, 1);
    lows = 0;
    while (!o_pload && lows < 10) begin lows++; cyc(1); end
    chk("refill_pload_width", lows, 2);
    cyc(5);
    chk("refill_q", int'(q_cnt), 100);
    chk("refill_pede", int'(o_pede_reposicao), 0);
    chk("refill_baixo", int'(o_baixo_estoque), 0);
    count_pload_lows(10, lows);
    chk("ok_held_no_reload", lows, 0);
    chk("ok_held_pede", int'(o_pede_reposicao), 0);
    repos_ok = 1'b0;
    cyc(4);

    // cork pulse while idle
    c0 = conta_events;
    pulse_sensor();
    cyc(8);
    chk("idle_sensor_no_count", conta_events - c0, 0);
    chk("idle_sensor_q", int'(q_cnt), 100);

    // cork pulse while waiting for the bottle to leave
    garrafa = 1'b1;
    n = 0;
    while (!o_valvula && n < 20) begin cyc(1); n++; end
    cyc(2);
    pulse_sensor();
    n = 0;
    while (!o_conta && n < 20) begin cyc(1); n++; end
    chk("saida_first_count", (n < 20) ? 1 : 0, 1);
    cyc(3);
    c0 = conta_events;
    pulse_sensor();
    cyc(8);
    chk("saida_sensor_no_count", conta_events - c0, 0);
    chk("saida_q", int'(q_cnt), 99);
    garrafa = 1'b0;
    cyc(8);

    // bottle removed mid-dispense: valve stays until the cork passes
    garrafa = 1'b1;
    n = 0;
    while (!o_valvula && n < 20) begin cyc(1); n++; end
    chk("drop_valve_open", int'(o_valvula), 1);
    garrafa = 1'b0;
    cyc(10);
    chk("drop_valve_held", int'(o_valvula), 1);
    pulse_sensor();
    n = 0;
    while (!o_conta && n < 20) begin cyc(1); n++; end
    chk("drop_counted", (n < 20) ? 1 : 0, 1);
    cyc(8);
    chk("drop_q", int'(q_cnt), 98);

    // bottle in, cork never arrives
    c0 = conta_events;
    garrafa = 1'b1;
    n = 0;
    while (!o_valvula && n < 20) begin cyc(1); n++; end
`ifdef ALARME_TIMEOUT_EN
    n = 0;
    while (!o_falha && n < 400) begin cyc(1); n++; end
    chk("timeout_cycles", n, 255);
    chk("timeout_valve", int'(o_valvula), 0);
    cyc(20);
    chk("falha_held", int'(o_falha), 1);
    chk("falha_valve_held", int'(o_valvula), 0);
`else
    cyc(300);
    chk("no_timeout_valve", int'(o_valvula), 1);
    chk("no_timeout_falha", int'(o_falha), 0);
`endif

    // reset with the cork outstanding
    rst = 1'b1;
    #1;
    chk("rst_async_valve", int'(o_valvula), 0);
    chk("rst_async_falha", int'(o_falha), 0);
    cyc(2);
    garrafa = 1'b0;
    rst = 1'b0;
    count_pload_lows(10, lows);
    chk("rerst_pload_width", lows, 2);
    chk("rerst_q", int'(q_cnt), 100);
    chk("rerst_no_count", conta_events - c0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/controlador_rolhas.md
Name: controlador_rolhas

Overview:
Sequencing controller for the cork-capping station.
- Directly upstream of, and consuming, the 7-bit parallel-load down counter that tracks corks left in the hopper.
- Drives the counter's load value P, its active-low load strobe PLoad and its count clock, and reads back Q.
- Opens the dispense valve per bottle, confirms each cork via sensor, requests hopper refill at zero and flags low stock.

Parameters:
CAPACIDADE, 100, cork count loaded into the counter after reset and after each refill (1..127).
LIMIAR_BAIXO, 10, BAIXO_ESTOQUE asserts while 0 < Q <= LIMIAR_BAIXO.
SYNC_STAGES, 2, flip-flop stages synchronising SENSOR_ROLHA, GARRAFA and REPOSICAO_OK.
TIMEOUT, 255, CLK cycles allowed between valve open and cork sensed (used only with the optional feature).

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous reset, active-high.
Q  input  7  current count from the down counter.
GARRAFA  input  1  bottle-in-position sensor (async, level).
SENSOR_ROLHA  input  1  cork-passed sensor (async, pulse >= 1 CLK).
REPOSICAO_OK  input  1  operator hopper-refilled acknowledge (async, level).
P  output  7  parallel load value to the counter; constant CAPACIDADE.
PLoad  output  1  counter load strobe, active-low.
CONTA  output  1  counter clock; counter decrements on its rising edge.
VALVULA  output  1  dispense valve open.
PEDE_REPOSICAO  output  1  refill request.
BAIXO_ESTOQUE  output  1  low-stock lamp.
FALHA  output  1  dispense fault; 0 when ALARME_TIMEOUT_EN is undefined.

Behaviour:
- One clock, CLK. RST is asynchronous and active-high; all state and outputs are registered.
- Reset values: state=CARGA, PLoad=1, CONTA=0, VALVULA=0, PEDE_REPOSICAO=0, BAIXO_ESTOQUE=0, FALHA=0.
- P is tied to CAPACIDADE at all times.
- Async inputs pass through SYNC_STAGES flops. SENSOR_ROLHA is rising-edge detected into a 1-cycle pulse, sensor_ev.

State machine (one state register):
- CARGA: PLoad=0 for exactly 2 cycles, then -> ESPERA_Q.
- ESPERA_Q: 2 settle cycles. Then if Q==0 -> REPOSICAO, else -> ESPERA_GARRAFA.
- ESPERA_GARRAFA: wait for synced GARRAFA=1 -> DISPENSA.
- DISPENSA: VALVULA=1 until sensor_ev, then -> CONTAGEM.
  - A sensor_ev while the block is not in DISPENSA is ignored.
- CONTAGEM: CONTA=1 for exactly 1 cycle, then -> ESPERA_SAIDA.
- ESPERA_SAIDA: wait for synced GARRAFA=0, then -> ESPERA_Q (the 2 settle cycles let Q resolve after the count).
- REPOSICAO: PEDE_REPOSICAO=1 until synced REPOSICAO_OK=1, then -> CARGA.

Timing and boundary rules:
- Latency, GARRAFA edge to VALVULA high: SYNC_STAGES+1 cycles.
- Latency, sensor_ev to CONTA high: 1 cycle.
- BAIXO_ESTOQUE is registered from Q every cycle, outside CARGA. Its range excludes 0; the empty condition is signalled by PEDE_REPOSICAO.
- Q==0 is never decremented, so no wrap to 127.
- Q > CAPACIDADE read back is treated as a valid count, with no special handling.
- REPOSICAO_OK already high on entry to REPOSICAO: exit after sync latency.
- REPOSICAO_OK held high after reload: no effect, because it is only sampled in REPOSICAO.
- GARRAFA dropping during DISPENSA: valve stays open until the cork is sensed (the cork must be accounted).
- RST mid-dispense: valve closes immediately and the counter is reloaded. An in-flight cork is not counted; this is accepted.
- CONTA and PLoad=0 are never asserted in the same cycle.

Optional Feature:
Macro ALARME_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in DISPENSA.
  - If it reaches TIMEOUT without sensor_ev: VALVULA=0, FALHA=1, state -> FALHA_ST.
  - FALHA_ST is left only by RST.
- Undefined:
  - No counter; DISPENSA waits indefinitely.
  - FALHA is tied to 0.

Test Plan:
- RST pulse, Q model loads on PLoad=0 -> PLoad low exactly 2 cycles, P=100, all other outputs 0, next state waits for GARRAFA.
- Q=100, GARRAFA high, sensor pulse after 5 cycles -> VALVULA high 3 cycles after GARRAFA edge, one 1-cycle CONTA pulse, Q=99, VALVULA drops.
- Repeat to Q=10 -> BAIXO_ESTOQUE rises at Q=10, stays high through Q=1.
- Q reaches 0 -> PEDE_REPOSICAO=1, no VALVULA on further GARRAFA. Assert REPOSICAO_OK -> PLoad pulse, Q=100, PEDE_REPOSICAO=0, BAIXO_ESTOQUE=0.
- Sensor pulses while idle or during ESPERA_SAIDA -> no CONTA, Q unchanged.
- With ALARME_TIMEOUT_EN and TIMEOUT=255, GARRAFA high, no sensor -> FALHA=1 and VALVULA=0 after 255 cycles, held until RST. Without the macro, the same stimulus leaves VALVULA=1 and FALHA=0.
